sprite_blitter: RTL and testbench

- Pipelined sprite renderer for the VGA path.
- Draws a palettized sprite ROM at a runtime (X,Y) position, with a power-of-two integer scale and a transparent colour key.
- Outside the sprite, and on transparent pixels, it passes the background colour through.
- Sits between the VGA controller's DrawX/DrawY/blank and the next compositor stage; the sprite ROM and palette stay outside the block.

---
 rtl/sprite_pkg.sv | 25 ++
 rtl/sprite_addr_gen.sv | 53 +++++
 rtl/sprite_blitter.sv | 202 ++++++++++++++++++++
 tb/tb_sprite_blitter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite blitter.
// rgb444_t carries one 4:4:4 pixel; texel_addr linearises a row/column pair.
package sprite_pkg;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   // Cycles from DrawX/blank/bg to the registered colour output.
   localparam int PIPE_LAT = 3;

   // Visible screen size of the VGA timing this block is used with.
   localparam int H_ACT = 640;
   localparam int V_ACT = 480;

   // Row-major texel address: row * width + column.
   function automatic int unsigned texel_addr(input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned w);
      return row * w + col;
   endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Stage-1 combinational logic: hit test against the latched sprite
// rectangle, texel scaling by a power of two, optional mirroring and
// ROM address arithmetic. Mirroring inputs are tied low by the top when
// the SPRITE_BLITTER_FLIP_EN build option is not enabled.
module sprite_addr_gen
   import sprite_pkg::*;
#(
   parameter int SPR_W    = 80,
   parameter int SPR_H    = 60,
   parameter int SCALE_SH = 0,
   parameter int ADDR_W   = 13
) (
   input  logic [9:0]        i_draw_x,
   input  logic [9:0]        i_draw_y,
   input  logic [9:0]        i_pos_x,
   input  logic [9:0]        i_pos_y,
   input  logic              i_en,
   input  logic              i_blank,
   input  logic              i_flip_x,
   input  logic              i_flip_y,
   output logic              o_hit,
   output logic [ADDR_W-1:0] o_addr
);

   logic [10:0] w_lx;
   logic [10:0] w_ly;
   logic [31:0] w_col;
   logic [31:0] w_row;
   logic [31:0] w_col_f;
   logic [31:0] w_row_f;
   logic        w_in_x;
   logic        w_in_y;

   // Offsets are 11-bit unsigned: pixels left of / above the sprite wrap
   // to large values and fail the range test, so there is no wrap-around.
   assign w_lx = {1'b0, i_draw_x} - {1'b0, i_pos_x};
   assign w_ly = {1'b0, i_draw_y} - {1'b0, i_pos_y};

   assign w_in_x = 32'(w_lx) < 32'(SPR_W << SCALE_SH);
   assign w_in_y = 32'(w_ly) < 32'(SPR_H << SCALE_SH);
   assign o_hit  = i_en & i_blank & w_in_x & w_in_y;

   // Texel coordinates: each texel spans 2^SCALE_SH pixels per axis.
   assign w_col = 32'(w_lx) >> SCALE_SH;
   assign w_row = 32'(w_ly) >> SCALE_SH;

   // Mirroring only matters on hit pixels, where col/row are in range.
   assign w_col_f = i_flip_x ? (32'(SPR_W - 1) - w_col) : w_col;
   assign w_row_f = i_flip_y ? (32'(SPR_H - 1) - w_row) : w_row;

   assign o_addr = ADDR_W'(texel_addr(w_row_f, w_col_f, 32'(SPR_W)));

endmodule

// File: rtl/sprite_blitter.sv
// Three-stage sprite renderer on the VGA pixel path.
// S1 hit test + ROM address, S2 ROM read, S3 palette lookup + colour mux.
// Also counts opaque sprite pixels per frame.
// Build option: SPRITE_BLITTER_FLIP_EN adds flip_x/flip_y mirroring inputs.
module sprite_blitter
   import sprite_pkg::*;
#(
   parameter int SPR_W      = 80,
   parameter int SPR_H      = 60,
   parameter int IDX_W      = 4,
   parameter int SCALE_SH   = 0,
   parameter int ADDR_W     = 13,
   parameter int TRANSP_IDX = 0
) (
   input  logic              vga_clk,
   input  logic              reset,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
   input  logic              spr_en,
   input  logic [3:0]        bg_red,
   input  logic [3:0]        bg_green,
   input  logic [3:0]        bg_blue,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [IDX_W-1:0]  rom_q,
   output logic [IDX_W-1:0]  pal_index,
   input  logic [3:0]        pal_red,
   input  logic [3:0]        pal_green,
   input  logic [3:0]        pal_blue,
   output logic [3:0]        red,
   output logic [3:0]        green,
   output logic [3:0]        blue,
   output logic [15:0]       opaque_count,
   output logic              count_valid
`ifdef SPRITE_BLITTER_FLIP_EN
   ,
   input  logic              flip_x,
   input  logic              flip_y
`endif
);

   logic [9:0]        r_px;
   logic [9:0]        r_py;
   logic              r_en;
   logic              w_flip_x;
   logic              w_flip_y;
   logic              w_frame_start;
   logic              w_hit;
   logic [ADDR_W-1:0] w_addr;
   logic [ADDR_W-1:0] r_rom_address;
   logic              r_hit1;
   logic              r_blank1;
   rgb444_t           r_bg1;
   logic              r_hit2;
   logic              r_blank2;
   rgb444_t           r_bg2;
   logic              w_opaque;
   rgb444_t           w_pix;
   rgb444_t           r_rgb;
   logic [15:0]       r_run;
   logic [15:0]       w_run_inc;
   logic [15:0]       r_opaque_count;
   logic              r_count_valid;

   assign w_frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);

   // Latch position/enable once per frame so mid-frame updates cannot tear.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         r_px <= '0;
         r_py <= '0;
         r_en <= 1'b0;
      end else if (w_frame_start) begin
         r_px <= pos_x;
         r_py <= pos_y;
         r_en <= spr_en;
      end
   end

`ifdef SPRITE_BLITTER_FLIP_EN
   logic r_flip_x;
   logic r_flip_y;

   // Mirroring flags follow the same frame latch as the position.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         r_flip_x <= 1'b0;
         r_flip_y <= 1'b0;
      end else if (w_frame_start) begin
         r_flip_x <= flip_x;
         r_flip_y <= flip_y;
      end
   end

   assign w_flip_x = r_flip_x;
   assign w_flip_y = r_flip_y;
`else
   assign w_flip_x = 1'b0;
   assign w_flip_y = 1'b0;
`endif

   sprite_addr_gen #(
      .SPR_W    (SPR_W),
      .SPR_H    (SPR_H),
      .SCALE_SH (SCALE_SH),
      .ADDR_W   (ADDR_W)
   ) u_addr_gen (
      .i_draw_x (DrawX),
      .i_draw_y (DrawY),
      .i_pos_x  (r_px),
      .i_pos_y  (r_py),
      .i_en     (r_en),
      .i_blank  (blank),
      .i_flip_x (w_flip_x),
      .i_flip_y (w_flip_y),
      .o_hit    (w_hit),
      .o_addr   (w_addr)
   );

   // S1: register ROM address (held on misses), hit, blank and background.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         r_rom_address <= '0;
         r_hit1        <= 1'b0;
         r_blank1      <= 1'b0;
         r_bg1         <= '0;
      end else begin
         if (w_hit) begin
            r_rom_address <= w_addr;
         end
         r_hit1   <= w_hit;
         r_blank1 <= blank;
         r_bg1    <= {bg_red, bg_green, bg_blue};
      end
   end

   // S2: delay side-band data while the ROM performs its read.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         r_hit2   <= 1'b0;
         r_blank2 <= 1'b0;
         r_bg2    <= '0;
      end else begin
         r_hit2   <= r_hit1;
         r_blank2 <= r_blank1;
         r_bg2    <= r_bg1;
      end
   end

   assign pal_index = rom_q;
   assign w_opaque  = r_blank2 & r_hit2 & (rom_q != IDX_W'(TRANSP_IDX));

   // S3 colour select: black outside active video, palette on opaque hits.
   always_comb begin
      w_pix = r_bg2;
      if (!r_blank2) begin
         w_pix = '0;
      end else if (w_opaque) begin
         w_pix = {pal_red, pal_green, pal_blue};
      end
   end

   // S3: register the final pixel colour.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         r_rgb <= '0;
      end else begin
         r_rgb <= w_pix;
      end
   end

   assign w_run_inc = (r_run != 16'hFFFF) ? (r_run + 16'd1) : r_run;

   // Opaque pixel counter: publish and restart at each frame latch; an
   // opaque pixel landing on that cycle belongs to the new frame.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         r_run          <= '0;
         r_opaque_count <= '0;
         r_count_valid  <= 1'b0;
      end else if (w_frame_start) begin
         r_opaque_count <= r_run;
         r_count_valid  <= 1'b1;
         r_run          <= w_opaque ? 16'd1 : 16'd0;
      end else begin
         r_count_valid <= 1'b0;
         if (w_opaque) begin
            r_run <= w_run_inc;
         end
      end
   end

   assign rom_address  = r_rom_address;
   assign red          = r_rgb.r;
   assign green        = r_rgb.g;
   assign blue         = r_rgb.b;
   assign opaque_count = r_opaque_count;
   assign count_valid  = r_count_valid;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: one unscaled instance placed by the
// bench and one 2x-scaled instance fixed at (0,0), each with its own
// synchronous ROM model and combinational palette.
module tb_sprite_blitter;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  draw_x;
   logic [9:0]  draw_y;
   logic        blank;
   logic [9:0]  pos_x;
   logic [9:0]  pos_y;
   logic        spr_en;
   logic        rom_mode;
   logic [3:0]  bg_r;
   logic [3:0]  bg_g;
   logic [3:0]  bg_b;
   logic        flip_x;
   logic        flip_y;

   logic [12:0] addr0;
   logic [12:0] addr1;
   logic [3:0]  rom_q0;
   logic [3:0]  rom_q1;
   logic [3:0]  pidx0;
   logic [3:0]  pidx1;
   logic [3:0]  red0, green0, blue0;
   logic [3:0]  red1, green1, blue1;
   logic [15:0] cnt0;
   logic [15:0] cnt1;
   logic        cv0;
   logic        cv1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // ROM contents: mode 0 = address-coded index, mode 1 = only texel 0 opaque.
   function automatic logic [3:0] rom_val(input logic [12:0] a, input logic m);
      if (m) begin
         return (a == 13'd0) ? 4'd5 : 4'd0;
      end
      return a[3:0] ^ 4'h5;
   endfunction

   always_ff @(posedge clk) rom_q0 <= rom_val(addr0, rom_mode);
   always_ff @(posedge clk) rom_q1 <= rom_val(addr1, 1'b0);

   sprite_blitter dut0 (
      .vga_clk      (clk),
      .reset        (reset),
      .DrawX        (draw_x),
      .DrawY        (draw_y),
      .blank        (blank),
      .pos_x        (pos_x),
      .pos_y        (pos_y),
      .spr_en       (spr_en),
      .bg_red       (bg_r),
      .bg_green     (bg_g),
      .bg_blue      (bg_b),
      .rom_address  (addr0),
      .rom_q        (rom_q0),
      .pal_index    (pidx0),
      .pal_red      (pidx0),
      .pal_green    (~pidx0),
      .pal_blue     (pidx0 ^ 4'h5),
      .red          (red0),
      .green        (green0),
      .blue         (blue0),
      .opaque_count (cnt0),
      .count_valid  (cv0)
`ifdef SPRITE_BLITTER_FLIP_EN
      ,
      .flip_x       (flip_x),
      .flip_y       (flip_y)
`endif
   );

   sprite_blitter #(.SCALE_SH(1)) dut1 (
      .vga_clk      (clk),
      .reset        (reset),
      .DrawX        (draw_x),
      .DrawY        (draw_y),
      .blank        (blank),
      .pos_x        (10'd0),
      .pos_y        (10'd0),
      .spr_en       (1'b1),
      .bg_red       (bg_r),
      .bg_green     (bg_g),
      .bg_blue      (bg_b),
      .rom_address  (addr1),
      .rom_q        (rom_q1),
      .pal_index    (pidx1),
      .pal_red      (pidx1),
      .pal_green    (~pidx1),
      .pal_blue     (pidx1 ^ 4'h5),
      .red          (red1),
      .green        (green1),
      .blue         (blue1),
      .opaque_count (cnt1),
      .count_valid  (cv1)
`ifdef SPRITE_BLITTER_FLIP_EN
      ,
      .flip_x       (1'b0),
      .flip_y       (1'b0)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one pixel and advance one clock; returns 1 time unit after the edge.
   task automatic step(input logic [9:0] x, input logic [9:0] y, input logic bl);
      draw_x = x;
      draw_y = y;
      blank  = bl;
      @(posedge clk);
      #1;
   endtask

   // Push one pixel through the pipeline: S1 addresses, then output 3 edges later.
   task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic bl,
                        output logic [12:0] a0, output logic [12:0] a1,
                        output logic [11:0] c0, output logic [11:0] c1);
      step(x, y, bl);
      a0 = addr0;
      a1 = addr1;
      step(10'd700, 10'd700, 1'b0);
      step(10'd700, 10'd700, 1'b0);
      c0 = {red0, green0, blue0};
      c1 = {red1, green1, blue1};
   endtask

   initial begin
      logic [12:0] a0, a1;
      logic [11:0] c0, c1;

      reset    = 1'b1;
      draw_x   = 10'd700;
      draw_y   = 10'd700;
      blank    = 1'b0;
      pos_x    = 10'd100;
      pos_y    = 10'd50;
      spr_en   = 1'b1;
      rom_mode = 1'b0;
      bg_r     = 4'hA;
      bg_g     = 4'hB;
      bg_b     = 4'hC;
      flip_x   = 1'b0;
      flip_y   = 1'b0;

      // Reset state
      step(10'd700, 10'd700, 1'b0);
      step(10'd700, 10'd700, 1'b0);
      chk("reset_rgb", {20'd0, red0, green0, blue0}, 32'h0);
      chk("reset_addr", {19'd0, addr0}, 32'h0);
      chk("reset_cnt", {16'd0, cnt0}, 32'h0);
      chk("reset_cv", {31'd0, cv0}, 32'h0);
      reset = 1'b0;
      step(10'd700, 10'd700, 1'b0);

      // Frame 1 latch: sprite at (100,50), previous count 0
      step(10'd0, 10'd0, 1'b1);
      chk("latch1_cv", {31'd0, cv0}, 32'h1);
      chk("latch1_cnt", {16'd0, cnt0}, 32'h0);
      step(10'd700, 10'd700, 1'b0);
      chk("latch1_cv_drop", {31'd0, cv0}, 32'h0);
      step(10'd700, 10'd700, 1'b0);
      chk("latch_pixel_bg", {20'd0, red0, green0, blue0}, 32'hABC);

      probe(10'd100, 10'd50, 1'b1, a0, a1, c0, c1);
      chk("tl_addr", {19'd0, a0}, 32'd0);
      chk("tl_rgb", {20'd0, c0}, 32'h5A0);
      probe(10'd101, 10'd50, 1'b1, a0, a1, c0, c1);
      chk("tl1_addr", {19'd0, a0}, 32'd1);
      chk("tl1_rgb", {20'd0, c0}, 32'h4B1);
      probe(10'd179, 10'd109, 1'b1, a0, a1, c0, c1);
      chk("br_addr", {19'd0, a0}, 32'd4799);
      chk("br_rgb", {20'd0, c0}, 32'hA5F);
      probe(10'd180, 10'd50, 1'b1, a0, a1, c0, c1);
      chk("right_hold_addr", {19'd0, a0}, 32'd4799);
      chk("right_bg", {20'd0, c0}, 32'hABC);
      probe(10'd100, 10'd110, 1'b1, a0, a1, c0, c1);
      chk("below_bg", {20'd0, c0}, 32'hABC);
      probe(10'd99, 10'd50, 1'b1, a0, a1, c0, c1);
      chk("left_bg", {20'd0, c0}, 32'hABC);
      probe(10'd100, 10'd50, 1'b0, a0, a1, c0, c1);
      chk("blanked_black", {20'd0, c0}, 32'h0);

      // Scale 2x instance at (0,0)
      probe(10'd1, 10'd0, 1'b1, a0, a1, c0, c1);
      chk("s1_x1_addr", {19'd0, a1}, 32'd0);
      chk("s1_x1_rgb", {20'd0, c1}, 32'h5A0);
      probe(10'd2, 10'd0, 1'b1, a0, a1, c0, c1);
      chk("s1_x2_addr", {19'd0, a1}, 32'd1);
      probe(10'd0, 10'd2, 1'b1, a0, a1, c0, c1);
      chk("s1_y2_addr", {19'd0, a1}, 32'd80);
      probe(10'd159, 10'd0, 1'b1, a0, a1, c0, c1);
      chk("s1_x159_addr", {19'd0, a1}, 32'd79);
      probe(10'd160, 10'd0, 1'b1, a0, a1, c0, c1);
      chk("s1_x160_bg", {20'd0, c1}, 32'hABC);

      // Frame 2: only texel 0 opaque; frame 1 had 3 opaque pixels
      rom_mode = 1'b1;
      step(10'd0, 10'd0, 1'b1);
      chk("latch2_cv", {31'd0, cv0}, 32'h1);
      chk("latch2_cnt", {16'd0, cnt0}, 32'd3);
      probe(10'd100, 10'd50, 1'b1, a0, a1, c0, c1);
      chk("m1_opaque", {20'd0, c0}, 32'h5A0);
      probe(10'd101, 10'd50, 1'b1, a0, a1, c0, c1);
      chk("m1_transp", {20'd0, c0}, 32'hABC);
      probe(10'd150, 10'd80, 1'b1, a0, a1, c0, c1);
      chk("m1_transp2", {20'd0, c0}, 32'hABC);
      rom_mode = 1'b0;
      step(10'd0, 10'd0, 1'b1);
      chk("latch3_cnt", {16'd0, cnt0}, 32'd1);
      chk("latch3_cv", {31'd0, cv0}, 32'h1);

      // Frame 3: pos_x moves mid-frame, old position still drawn
      pos_x = 10'd300;
      probe(10'd100, 10'd50, 1'b1, a0, a1, c0, c1);
      chk("nomove_old", {20'd0, c0}, 32'h5A0);
      probe(10'd300, 10'd50, 1'b1, a0, a1, c0, c1);
      chk("nomove_new", {20'd0, c0}, 32'hABC);
      step(10'd0, 10'd0, 1'b1);
      chk("latch4_cnt", {16'd0, cnt0}, 32'd1);
      probe(10'd300, 10'd50, 1'b1, a0, a1, c0, c1);
      chk("moved_addr", {19'd0, a0}, 32'd0);
      chk("moved_new", {20'd0, c0}, 32'h5A0);
      probe(10'd100, 10'd50, 1'b1, a0, a1, c0, c1);
      chk("moved_old", {20'd0, c0}, 32'hABC);

      // Frame 5: sprite at (600,450) clipped at the screen edge
      pos_x = 10'd600;
      pos_y = 10'd450;
      step(10'd0, 10'd0, 1'b1);
      probe(10'd639, 10'd479, 1'b1, a0, a1, c0, c1);
      chk("clip_addr", {19'd0, a0}, 32'd2359);
      chk("clip_rgb", {20'd0, c0}, 32'h2D7);
      probe(10'd640, 10'd479, 1'b0, a0, a1, c0, c1);
      chk("clip_blank", {20'd0, c0}, 32'h0);
      probe(10'd10, 10'd460, 1'b1, a0, a1, c0, c1);
      chk("nowrap_x10", {20'd0, c0}, 32'hABC);
      probe(10'd30, 10'd470, 1'b1, a0, a1, c0, c1);
      chk("nowrap_x30", {20'd0, c0}, 32'hABC);

      // Reset mid-frame
      probe(10'd620, 10'd460, 1'b1, a0, a1, c0, c1);
      chk("pre_rst_addr", {19'd0, a0}, 32'd820);
      chk("pre_rst_rgb", {20'd0, c0}, 32'h1E4);
      reset = 1'b1;
      step(10'd700, 10'd700, 1'b0);
      reset = 1'b0;
      chk("rst_rgb", {20'd0, red0, green0, blue0}, 32'h0);
      chk("rst_addr", {19'd0, addr0}, 32'h0);
      chk("rst_cnt", {16'd0, cnt0}, 32'h0);
      probe(10'd620, 10'd460, 1'b1, a0, a1, c0, c1);
      chk("rst_hidden", {20'd0, c0}, 32'hABC);
      step(10'd0, 10'd0, 1'b1);
      chk("rst_latch_cv", {31'd0, cv0}, 32'h1);
      chk("rst_latch_cnt", {16'd0, cnt0}, 32'h0);
      probe(10'd620, 10'd460, 1'b1, a0, a1, c0, c1);
      chk("rst_relatch", {20'd0, c0}, 32'h1E4);

`ifdef SPRITE_BLITTER_FLIP_EN
      // Horizontal mirror
      pos_x  = 10'd100;
      pos_y  = 10'd50;
      flip_x = 1'b1;
      step(10'd0, 10'd0, 1'b1);
      probe(10'd100, 10'd50, 1'b1, a0, a1, c0, c1);
      chk("flip_x_addr", {19'd0, a0}, 32'd79);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
